// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-ISA datapath with integrated sequencer.
// One shared memory port carries instruction fetches and LW/SW traffic.
module multicycle_datapath #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned PC_RESET = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              overflow,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_alu_out
);
    localparam int SHW = $clog2(DATA_W);
    localparam int M   = DATA_W - 1;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_BNE  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_a, r_b, r_mdr, r_alu;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_regs [8];

    logic [2:0]          w_op, w_rs, w_rt, w_rd;
    logic [3:0]          w_funct;
    logic [DATA_W-1:0]   w_sext, w_opb, w_sum, w_diff, w_alu, w_rs_val, w_rt_val;
    logic                w_ovf, w_take;
    logic [ADDR_W-1:0]   w_br_off, w_jmp;

    assign w_op     = r_ir[15:13];
    assign w_rs     = r_ir[12:10];
    assign w_rt     = r_ir[9:7];
    assign w_rd     = r_ir[6:4];
    assign w_funct  = r_ir[3:0];
    assign w_sext   = DATA_W'($signed(r_ir[6:0]));
    assign w_br_off = ADDR_W'($signed({r_ir[6:0], 1'b0}));
    assign w_jmp    = ADDR_W'({r_ir[12:0], 1'b0});

    // r0 is hard-wired to zero on the read side; writes to it are dropped in WB.
    assign w_rs_val = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? '0 : r_regs[w_rt];

    assign w_opb  = (w_op == OP_R) ? r_b : w_sext;
    assign w_sum  = r_a + w_opb;
    assign w_diff = r_a - r_b;
    assign w_take = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    4'd0: begin
                        w_alu = w_sum;
                        w_ovf = (r_a[M] == r_b[M]) && (w_sum[M] != r_a[M]);
                    end
                    4'd1: begin
                        w_alu = w_diff;
                        w_ovf = (r_a[M] != r_b[M]) && (w_diff[M] != r_a[M]);
                    end
                    4'd2: w_alu = r_a & r_b;
                    4'd3: w_alu = r_a | r_b;
                    4'd4: w_alu = r_a ^ r_b;
                    4'd5: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                    4'd6: w_alu = r_a << r_b[SHW-1:0];
                    4'd7: w_alu = r_a >> r_b[SHW-1:0];
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI: begin
                w_alu = w_sum;
                w_ovf = (r_a[M] == w_sext[M]) && (w_sum[M] != r_a[M]);
            end
            OP_LW, OP_SW: w_alu = w_sum;
            default: w_alu = w_diff;
        endcase
    end

    // Port signals depend only on registered state, so they stay stable during wait cycles.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = r_b;
        case (r_state)
            S_FETCH: begin
                mem_req = !Reset;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = (w_op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_BEQ, OP_BNE, OP_JMP: w_next = S_FETCH;
                    OP_LW, OP_SW:           w_next = S_MEM;
                    default:                w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = !Reset;
                mem_we   = !Reset && (w_op == OP_SW);
                mem_addr = ADDR_W'(r_alu);
                if (mem_ready) w_next = (w_op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_pc    <= ADDR_W'(PC_RESET);
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mdr   <= '0;
            r_alu   <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata[15:0];
                        r_pc <= r_pc + ADDR_W'(2);
                    end
                end
                S_DECODE: begin
                    r_a <= w_rs_val;
                    r_b <= w_rt_val;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_ovf) r_ovf <= 1'b1;
                    if (w_take) r_pc <= r_pc + w_br_off;
                    else if (w_op == OP_JMP) r_pc <= w_jmp;
                end
                S_MEM: begin
                    if (mem_ready && (w_op == OP_LW)) r_mdr <= mem_rdata;
                end
                S_WB: begin
                    if ((w_op == OP_R) && !w_funct[3] && (w_rd != 3'd0)) r_regs[w_rd] <= r_alu;
                    else if ((w_op == OP_ADDI) && (w_rt != 3'd0))        r_regs[w_rt] <= r_alu;
                    else if ((w_op == OP_LW) && (w_rt != 3'd0))          r_regs[w_rt] <= r_mdr;
                end
                default: ;
            endcase
        end
    end

    assign halted      = (r_state == S_HALT);
    assign overflow    = r_ovf;
    assign dbg_pc      = r_pc;
    assign dbg_alu_out = r_alu;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: stimulus queues expected memory handshakes, a monitor pops and checks them.
// A second instance with DATA_W=32 reruns the 0x8000 addition case.
module tb_multicycle_datapath;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst1 = 1'b1, ld0 = 1'b0, ld1 = 1'b0;
    logic        req0, we0, rdy0, halted0, ovf0;
    logic [15:0] addr0, wdata0, rdata0, pc0, alu0;
    logic        req1, we1, halted1, ovf1;
    logic        rdy1 = 1'b1;
    logic [15:0] addr1, pc1;
    logic [31:0] wdata1, rdata1, alu1;

    int checks = 0, failures = 0, cyc = 0;
    int fetch_wait = 0, data_wait = 0, wcnt0 = 0, need0, wr1 = 0;

    logic [31:0] img  [0:1023];
    logic [15:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    typedef struct {
        int          kind;   // 0 fetch, 1 data read, 2 write
        logic [15:0] addr;
        logic [31:0] data;
        int          gap;
        logic [31:0] alu;
        bit          alu_chk;
        bit          ovf;
    } ev_t;
    ev_t q0[$];

    multicycle_datapath #(.DATA_W(16), .ADDR_W(16), .PC_RESET(10)) u0 (
        .Clock(clk), .Reset(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(rdy0), .halted(halted0),
        .overflow(ovf0), .dbg_pc(pc0), .dbg_alu_out(alu0));

    multicycle_datapath #(.DATA_W(32), .ADDR_W(16), .PC_RESET(10)) u1 (
        .Clock(clk), .Reset(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(rdy1), .halted(halted1),
        .overflow(ovf1), .dbg_pc(pc1), .dbg_alu_out(alu1));

    // Addresses below 10 are data; they see data_wait stall cycles, everything else fetch_wait.
    always_comb need0 = (addr0 < 16'd10) ? data_wait : fetch_wait;
    assign rdy0   = (wcnt0 >= need0);
    assign rdata0 = mem0[addr0[9:0]];
    assign rdata1 = mem1[addr1[9:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt0 <= (req0 && !rdy0) ? wcnt0 + 1 : 0;
        if (ld0) for (int i = 0; i < 1024; i++) mem0[i] <= img[i][15:0];
        else if (req0 && we0 && rdy0) mem0[addr0[9:0]] <= wdata0;
        if (ld1) for (int i = 0; i < 1024; i++) mem1[i] <= img[i];
        else if (req1 && we1 && rdy1) mem1[addr1[9:0]] <= wdata1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] R(input int rs, input int rt, input int rd, input int f);
        return {3'b000, rs[2:0], rt[2:0], rd[2:0], f[3:0]};
    endfunction
    function automatic logic [15:0] I(input int op, input int rs, input int rt, input int imm);
        return {op[2:0], rs[2:0], rt[2:0], imm[6:0]};
    endfunction
    function automatic logic [15:0] J(input int ji);
        return {3'b110, ji[12:0]};
    endfunction
    localparam logic [15:0] HALT = 16'hE000;

    task automatic clr();
        for (int i = 0; i < 1024; i++) img[i] = '0;
    endtask
    task automatic put(input int a, input logic [15:0] w);
        img[a] = {16'h0, w};
    endtask
    task automatic ef(input int a, input int g, input int al, input bit ck, input bit o);
        ev_t e;
        e.kind = 0; e.addr = a[15:0]; e.data = '0; e.gap = g; e.alu = al; e.alu_chk = ck; e.ovf = o;
        q0.push_back(e);
    endtask
    task automatic er(input int a);
        ev_t e;
        e.kind = 1; e.addr = a[15:0]; e.data = '0; e.gap = 0; e.alu = '0; e.alu_chk = 0; e.ovf = 0;
        q0.push_back(e);
    endtask
    task automatic ew(input int a, input int d);
        ev_t e;
        e.kind = 2; e.addr = a[15:0]; e.data = d; e.gap = 0; e.alu = '0; e.alu_chk = 0; e.ovf = 0;
        q0.push_back(e);
    endtask

    // Monitor for u0: handshake scoreboard plus hold-stability of a stalled request.
    initial begin
        ev_t e;
        int last_f = -1;
        bit pend = 0;
        logic [15:0] paddr, pwd;
        logic pwe;
        forever begin
            @(negedge clk);
            if (rst0) begin
                last_f = -1;
                pend = 0;
            end else begin
                if (pend && req0) begin
                    chk("hold_addr", addr0, paddr);
                    chk("hold_we", we0, pwe);
                    chk("hold_wdata", wdata0, pwd);
                end
                pend = req0 && !rdy0;
                paddr = addr0; pwe = we0; pwd = wdata0;
                if (req0 && rdy0) begin
                    if (q0.size() == 0) begin
                        chk("unexpected_xfer_addr", addr0, 16'hFFFF);
                    end else begin
                        e = q0.pop_front();
                        chk($sformatf("we@%0h", e.addr), we0, (e.kind == 2));
                        chk($sformatf("addr@%0h", e.addr), addr0, e.addr);
                        if (e.kind == 2) chk($sformatf("wdata@%0h", e.addr), wdata0, e.data);
                        if (e.kind == 0) begin
                            chk($sformatf("dbg_pc@%0h", e.addr), pc0, e.addr);
                            chk($sformatf("ovf@%0h", e.addr), ovf0, e.ovf);
                            if (e.gap > 0 && last_f >= 0) chk($sformatf("gap@%0h", e.addr), cyc - last_f, e.gap);
                            if (e.alu_chk) chk($sformatf("alu@%0h", e.addr), alu0, e.alu);
                            last_f = cyc;
                        end
                    end
                end
            end
        end
    end

    // Monitor for u1: only its single store is of interest.
    initial forever begin
        @(negedge clk);
        if (!rst1 && req1 && we1) begin
            chk("w32_addr", addr1, 16'h0);
            chk("w32_data", wdata1, 32'h8000);
            wr1++;
        end
    end

    task automatic start0(input bit full);
        rst0 = 1'b1; ld0 = 1'b1;
        @(posedge clk); #1 ld0 = 1'b0;
        @(posedge clk); #1;
        if (full) begin
            @(negedge clk);
            chk("rst_req", req0, 0);
            chk("rst_we", we0, 0);
            chk("rst_pc", pc0, 10);
            chk("rst_addr", addr0, 10);
            chk("rst_wdata", wdata0, 0);
            chk("rst_halted", halted0, 0);
            chk("rst_ovf", ovf0, 0);
            chk("rst_alu", alu0, 0);
            @(posedge clk); #1;
        end
        rst0 = 1'b0;
        if (full) begin
            @(negedge clk);
            chk("first_req", req0, 1);
            chk("first_addr", addr0, 10);
        end
    endtask

    task automatic run0(input int budget);
        int n = 0;
        while (!halted0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("halt_reached", halted0, 1);
        @(negedge clk);
        chk("queue_drained", q0.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // A: ALU ops, NOP funct, SW/LW with 3 stall cycles on each data access.
        clr();
        put(10, I(1,0,1,5));  put(12, I(1,0,2,3));  put(14, R(1,2,3,1));  put(16, R(2,1,4,5));
        put(18, R(1,2,5,6));  put(20, R(1,2,3,9));  put(22, I(3,0,3,0));  put(24, I(3,0,1,4));
        put(26, I(2,0,6,4));  put(28, I(3,0,6,6));  put(30, I(3,0,4,2));  put(32, I(3,0,5,8));
        put(34, HALT);
        data_wait = 3; fetch_wait = 0;
        ef(10,0,0,0,0);  ef(12,4,5,1,0);  ef(14,4,3,1,0);  ef(16,4,2,1,0);  ef(18,4,1,1,0);
        ef(20,4,40,1,0); ef(22,4,0,0,0);  ew(0,2);  ef(24,7,0,1,0);  ew(4,5);  ef(26,7,4,1,0);
        er(4); ef(28,8,4,1,0); ew(6,5); ef(30,7,6,1,0); ew(2,1); ef(32,7,2,1,0); ew(8,40); ef(34,7,8,1,0);
        start0(1);
        run0(400);

        // B: JMP, BNE taken backward / not taken, BEQ taken forward / not taken.
        clr();
        put(10, I(1,0,2,2));  put(12, J(10));  put(20, I(1,1,1,1));  put(22, I(5,1,2,7'h7E));
        put(24, I(4,1,2,2));  put(26, HALT);   put(30, I(4,0,1,7'h7E)); put(32, J(16'h40));
        put(16'h80, I(3,0,1,0)); put(16'h82, HALT);
        data_wait = 0;
        ef(10,0,0,0,0); ef(12,4,2,1,0); ef(20,3,0,0,0); ef(22,4,1,1,0); ef(20,3,0,0,0);
        ef(22,4,2,1,0); ef(24,3,0,0,0); ef(30,3,0,0,0); ef(32,3,0,0,0); ef(16'h80,3,0,0,0);
        ew(0,2); ef(16'h82,4,0,1,0);
        start0(0);
        run0(400);

        // C: signed overflow at 0x7FFF+1, sticky flag, write to r0 ignored.
        clr();
        put(10, I(1,0,1,7'h7F)); put(12, I(1,0,3,1)); put(14, R(1,3,2,7)); put(16, R(2,3,4,0));
        put(18, R(3,3,5,0));     put(20, I(1,7,0,1)); put(22, I(3,0,0,0)); put(24, I(3,0,4,2));
        put(26, HALT);
        ef(10,0,0,0,0); ef(12,4,'hFFFF,1,0); ef(14,4,1,1,0); ef(16,4,'h7FFF,1,0);
        ef(18,4,'h8000,1,1); ef(20,4,2,1,1); ef(22,4,1,1,1); ew(0,0); ef(24,4,0,1,1);
        ew(2,'h8000); ef(26,4,2,1,1);
        start0(0);
        run0(400);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_hold", halted0, 1);
            chk("halt_noreq", req0, 0);
        end

        // D: reset during a stalled fetch; registers and flags must come back cleared.
        clr();
        put(10, I(3,0,1,0)); put(12, I(3,0,4,2)); put(14, I(3,0,5,4)); put(16, HALT);
        ef(10,0,0,0,0); ew(0,0); ef(12,4,0,1,0); ew(2,0); ef(14,4,2,1,0); ew(4,0); ef(16,4,4,1,0);
        fetch_wait = 100;
        start0(0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_req", req0, 1);
        chk("stall_addr", addr0, 10);
        @(posedge clk); #1 rst0 = 1'b1;
        @(negedge clk);
        chk("midrst_noreq", req0, 0);
        @(posedge clk); #1;
        chk("midrst_pc", pc0, 10);
        chk("midrst_halted", halted0, 0);
        chk("midrst_ovf", ovf0, 0);
        fetch_wait = 0;
        rst0 = 1'b0;
        run0(400);

        // E: DATA_W=32 instance, 0x7FFF+1 is not an overflow there.
        clr();
        put(10, I(1,0,1,1)); put(12, I(1,0,3,15)); put(14, R(1,3,2,6)); put(16, I(1,2,4,7'h7F));
        put(18, R(4,1,5,0)); put(20, I(3,0,5,0));  put(22, HALT);
        ld1 = 1'b1;
        @(posedge clk); #1 ld1 = 1'b0;
        @(posedge clk); #1 rst1 = 1'b0;
        for (int n = 0; n < 400 && !halted1; n++) @(posedge clk);
        @(negedge clk);
        chk("w32_halted", halted1, 1);
        chk("w32_writes", wr1, 1);
        chk("w32_ovf", ovf1, 0);
        chk("w32_alu", alu1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
